divide_seq: RTL and testbench

- Parametrised sequential restoring divider: DW-bit unsigned dividend, runtime VW-bit unsigned divisor, one quotient bit per clock.
- Generalises the fixed divide-by-10 unit used by the display path. Adds runtime divisor, divide-by-zero detection, a one-cycle done pulse and output registers that hold during computation.
- Sits between the binary counter/value source and BCD/seven-segment formatting.

---
 rtl/divide_pkg.sv | 9 +
 rtl/divide_step.sv | 16 +
 rtl/divide_seq.sv | 103 ++++++++++
 tb/tb_divide_seq.sv | 129 ++++++++++++
 4 files changed

// File: rtl/divide_pkg.sv
// divide_pkg: shared types, defaults and helpers for the sequential divider.
package divide_pkg;
    typedef enum logic {IDLE, RUN} state_e;
    localparam int DW_DEF = 14;
    localparam int VW_DEF = 4;
    function automatic int cnt_w(input int dw);
        return $clog2(dw + 1);
    endfunction
endpackage

// File: rtl/divide_step.sv
// divide_step: one combinational restoring-division step (shift in one dividend bit, trial subtract).
module divide_step #(
    parameter int VW = 4
) (
    input  logic [VW:0]   partial_i,
    input  logic          msb_i,
    input  logic [VW-1:0] divisor_i,
    output logic [VW:0]   partial_o,
    output logic          qbit_o
);
    logic [VW:0] shifted;
    assign shifted = {partial_i[VW-1:0], msb_i};
    // partial_i[VW] is always clear while remainder < divisor; folding it in keeps the compare exact regardless
    assign qbit_o    = partial_i[VW] | (shifted >= {1'b0, divisor_i});
    assign partial_o = qbit_o ? shifted - {1'b0, divisor_i} : shifted;
endmodule

// File: rtl/divide_seq.sv
// divide_seq: sequential restoring divider, one quotient bit per clock,
// runtime divisor with divide-by-zero flag and a one-cycle done pulse.
module divide_seq
    import divide_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          ready,
    output logic          done,
    output logic          div_by_zero
);
    localparam int CW = cnt_w(DW);

    state_e        state_q, state_d;
    logic [DW-1:0] shift_q, shift_d, quot_q, quot_d;
    logic [VW-1:0] div_q, div_d, rem_q, rem_d;
    logic [VW:0]   part_q, part_d, part_next;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d, dbz_q, dbz_d, qbit;

    divide_step #(.VW(VW)) u_step (
        .partial_i(part_q),
        .msb_i    (shift_q[DW-1]),
        .divisor_i(div_q),
        .partial_o(part_next),
        .qbit_o   (qbit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            div_q   <= '0;
            part_q  <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            div_q   <= div_d;
            part_q  <= part_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        div_d   = div_q;
        part_d  = part_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        if (state_q == IDLE) begin
            if (start && divisor != '0) begin
                state_d = RUN;
                shift_d = dividend;
                div_d   = divisor;
                part_d  = '0;
                cnt_d   = CW'(DW);
            end else if (start) begin
                quot_d = '1;
                rem_d  = '0;
                dbz_d  = 1'b1;
                done_d = 1'b1;
            end
        end else begin
            shift_d = {shift_q[DW-2:0], qbit};
            part_d  = part_next;
            cnt_d   = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_d = IDLE;
                quot_d  = shift_d;
                rem_d   = part_next[VW-1:0];
                dbz_d   = 1'b0;
                done_d  = 1'b1;
            end
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign ready       = (state_q == IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_divide_seq.sv
// tb_divide_seq: directed plus random operations checked against plain / and % arithmetic.
module tb_divide_seq;
    localparam int DW = 14;
    localparam int VW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] dividend = '0;
    logic [VW-1:0] divisor = '0;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          ready, done, div_by_zero;

    int errors = 0;
    int checks = 0;
    int pq = 0, pr = 0, pz = 0;

    divide_seq #(.DW(DW), .VW(VW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .ready      (ready),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic held(input string tag, input logic rdy);
        chk({tag, " quotient held"}, 32'(quotient), 32'(pq));
        chk({tag, " remainder held"}, 32'(remainder), 32'(pr));
        chk({tag, " dbz held"}, 32'(div_by_zero), 32'(pz));
        chk({tag, " done low"}, 32'(done), 0);
        chk({tag, " ready"}, 32'(ready), 32'(rdy));
    endtask

    // Issues one operation at the current cycle and checks every edge up to its completion.
    // glitch_at>0 pulses a competing start that many edges into RUN.
    task automatic op(input string tag, input int dd, input int dv, input int glitch_at);
        int eq, er;
        eq = (dv == 0) ? (1 << DW) - 1 : dd / dv;
        er = (dv == 0) ? 0 : dd % dv;
        start = 1'b1;
        dividend = DW'(dd);
        divisor = VW'(dv);
        @(posedge clk); #1;
        start = 1'b0;
        dividend = DW'($urandom);
        divisor = VW'($urandom);
        if (dv != 0) begin
            held({tag, " accept"}, 1'b0);
            for (int i = 1; i < DW; i++) begin
                @(posedge clk); #1;
                start = (i == glitch_at);
                if (i == glitch_at) begin
                    dividend = DW'($urandom);
                    divisor = VW'($urandom_range(1, 15));
                end
                if (i == 1 || i == DW - 1 || i == glitch_at + 1) held({tag, " run"}, 1'b0);
            end
            start = 1'b0;
            @(posedge clk); #1;
        end
        chk({tag, " quotient"}, 32'(quotient), 32'(eq));
        chk({tag, " remainder"}, 32'(remainder), 32'(er));
        chk({tag, " dbz"}, 32'(div_by_zero), 32'(dv == 0));
        chk({tag, " done"}, 32'(done), 1);
        chk({tag, " ready"}, 32'(ready), 1);
        pq = eq;
        pr = er;
        pz = (dv == 0);
    endtask

    task automatic idle_cycle(input string tag);
        @(posedge clk); #1;
        held(tag, 1'b1);
    endtask

    initial begin
        #50;
        held("reset", 1'b1);
        #50 rst = 1'b1;
        @(posedge clk); #1;
        op("4934/10", 4934, 10, 0);
        op("0/10 b2b", 0, 10, 0);
        idle_cycle("gap1");
        op("16383/15", 16383, 15, 0);
        op("9/10", 9, 10, 0);
        idle_cycle("gap2");
        op("100/0", 100, 0, 0);
        op("50/7", 50, 7, 0);
        idle_cycle("gap3");
        op("ignored start", 4934, 10, 5);
        idle_cycle("gap4");
        start = 1'b1;
        dividend = DW'(4000);
        divisor = VW'(3);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        pq = 0; pr = 0; pz = 0;
        held("mid-run reset", 1'b1);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        op("1234/9", 1234, 9, 0);
        for (int n = 0; n < 12; n++) begin
            if (n % 2 == 1) idle_cycle("rand gap");
            op("random", int'($urandom_range(0, (1 << DW) - 1)), int'($urandom_range(0, 15)), 0);
        end
        idle_cycle("final");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
